// File: rtl/bkram_sd_sequencer.sv
// bkram_sd_sequencer: sequences BRAM save/load sector transfers over the HPS SD
// interface and writes a formatted BRAM image through BRAM port B.
module bkram_sd_sequencer #(
    parameter int NSECT_LOG2 = 4,
    parameter int TO_BITS    = 24
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  bk_ena,
    input  logic                  load_req,
    input  logic                  save_req,
    input  logic                  format_req,
    input  logic [1:0]            slot,
    input  logic                  sd_ack,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    output logic                  port_sel,
    output logic [NSECT_LOG2+7:0] fmt_addr,
    output logic [15:0]           fmt_data,
    output logic                  fmt_we,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int AW = NSECT_LOG2 + 8;

    typedef enum logic [1:0] {IDLE, REQ, XFER, FMT} state_t;

    state_t             state, state_d;
    logic [31:0]        lba_d;
    logic               rd_d, wr_d, ps_d, we_d, hold_d, busy_d, done_d, err_d;
    logic [AW-1:0]      addr_d, addr_nx;
    logic [15:0]        data_d;
    logic [TO_BITS-1:0] cnt, cnt_d, cnt_inc;
    logic               old_load, old_save, old_fmt, old_ack;
    logic               ld_ev, sv_ev, fm_ev, ack_rise, ack_fall;

    assign ld_ev    = load_req & ~old_load;
    assign sv_ev    = save_req & ~old_save;
    assign fm_ev    = format_req & ~old_fmt;
    assign ack_rise = sd_ack & ~old_ack;
    assign ack_fall = ~sd_ack & old_ack;
    assign cnt_inc  = cnt + TO_BITS'(1);
    assign addr_nx  = fmt_addr + AW'(1);

    // Header words of an empty BRAM image; everything past word 3 is zero.
    function automatic logic [15:0] fmt_word(input logic [AW-1:0] a);
        return a == AW'(0) ? 16'h5548 :
               a == AW'(1) ? 16'h4D42 :
               a == AW'(2) ? 16'h8800 :
               a == AW'(3) ? 16'h8010 : 16'h0000;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sd_lba    <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            port_sel  <= 1'b1;
            fmt_addr  <= '0;
            fmt_data  <= '0;
            fmt_we    <= 1'b0;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            old_load  <= 1'b1;
            old_save  <= 1'b1;
            old_fmt   <= 1'b1;
            old_ack   <= 1'b1;
        end else begin
            state     <= state_d;
            sd_lba    <= lba_d;
            sd_rd     <= rd_d;
            sd_wr     <= wr_d;
            port_sel  <= ps_d;
            fmt_addr  <= addr_d;
            fmt_data  <= data_d;
            fmt_we    <= we_d;
            core_hold <= hold_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            cnt       <= cnt_d;
            old_load  <= load_req;
            old_save  <= save_req;
            old_fmt   <= format_req;
            old_ack   <= sd_ack;
        end
    end

    always_comb begin
        state_d = state;
        lba_d   = sd_lba;
        rd_d    = sd_rd;
        wr_d    = sd_wr;
        ps_d    = port_sel;
        addr_d  = fmt_addr;
        data_d  = fmt_data;
        we_d    = fmt_we;
        hold_d  = core_hold;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (fm_ev) begin
                    addr_d  = '0;
                    data_d  = fmt_word('0);
                    we_d    = 1'b1;
                    ps_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FMT;
                end else if (bk_ena && (ld_ev || sv_ev)) begin
                    lba_d   = 32'({slot, {NSECT_LOG2{1'b0}}});
                    rd_d    = ld_ev;
                    wr_d    = ~ld_ev;
                    hold_d  = ld_ev;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = XFER;
                end else if (&cnt_inc) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            XFER: begin
                if (ack_fall && (&sd_lba[NSECT_LOG2-1:0])) begin
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ack_fall) begin
                    // core_hold doubles as the load/save direction of the running job
                    lba_d   = sd_lba + 32'd1;
                    rd_d    = core_hold;
                    wr_d    = ~core_hold;
                    state_d = REQ;
                end
            end
            FMT: begin
                if (&fmt_addr) begin
                    we_d    = 1'b0;
                    data_d  = '0;
                    ps_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d = addr_nx;
                    data_d = fmt_word(addr_nx);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bkram_sd_sequencer.sv
// tb_bkram_sd_sequencer: vector table, randomized transfers against a sector-list
// model, format image check, timeout abort and mid-load reset.
module tb_bkram_sd_sequencer;
    localparam int N   = 4;
    localparam int TOB = 4;
    localparam int AW  = N + 8;

    logic          clk_sys = 0, reset_n = 1;
    logic          bk_ena = 0, load_req = 0, save_req = 0, format_req = 0, sd_ack = 0;
    logic [1:0]    slot = 0;
    logic [31:0]   sd_lba;
    logic          sd_rd, sd_wr, port_sel, fmt_we, core_hold, busy, done, err;
    logic [AW-1:0] fmt_addr;
    logic [15:0]   fmt_data;

    int checks = 0, errors = 0;
    bit hps_en = 1, hps_rand = 0;
    logic [31:0] obs_lba[$];
    bit obs_rd[$];
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    bit prev_req = 0;

    typedef struct {
        bit bk, ld, sv, fm;
        bit rd, wr, ps, bsy;
    } vec_t;
    vec_t vecs[8];

    bkram_sd_sequencer #(.NSECT_LOG2(N), .TO_BITS(TOB)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena), .load_req(load_req),
        .save_req(save_req), .format_req(format_req), .slot(slot), .sd_ack(sd_ack),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .port_sel(port_sel),
        .fmt_addr(fmt_addr), .fmt_data(fmt_data), .fmt_we(fmt_we),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    // HPS side: acknowledge each sector request after a delay, hold ack two cycles
    initial begin
        int d;
        forever begin
            @(negedge clk_sys);
            if (hps_en && reset_n && (sd_rd || sd_wr) && !sd_ack) begin
                d = hps_rand ? int'($urandom_range(1, 8)) : 5;
                repeat (d) @(negedge clk_sys);
                sd_ack = 1;
                repeat (2) @(negedge clk_sys);
                sd_ack = 0;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (!reset_n) prev_req = 0;
        else begin
            if ((sd_rd || sd_wr) && !prev_req) begin
                obs_lba.push_back(sd_lba);
                obs_rd.push_back(sd_rd);
            end
            if (sd_rd && sd_wr) both_cnt++;
            prev_req = sd_rd || sd_wr;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    function automatic logic [15:0] fmt_model(input int a);
        return a == 0 ? 16'h5548 : a == 1 ? 16'h4D42 : a == 2 ? 16'h8800 :
               a == 3 ? 16'h8010 : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input bit hold, input bit noise, output int hb);
        int n;
        bit fin;
        n = 0;
        fin = 0;
        hb = 0;
        while (!fin && n < 6000) begin
            @(negedge clk_sys);
            n++;
            if (!busy) fin = 1;
            else begin
                if (core_hold !== hold) hb++;
                if (noise) begin
                    slot = 2'($urandom);
                    bk_ena = 1'($urandom);
                end
            end
        end
        chk("idle_within_bound", 32'(fin), 1);
        @(negedge clk_sys);
    endtask

    task automatic do_xfer(input logic [1:0] s, input bit ld, input bit noise);
        int d0, e0, b0, hb, bad;
        bk_ena = 1;
        slot = s;
        obs_lba.delete();
        obs_rd.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        b0 = both_cnt;
        @(negedge clk_sys);
        if (ld) load_req = 1;
        else save_req = 1;
        wait_idle(ld, noise, hb);
        load_req = 0;
        save_req = 0;
        bk_ena = 1;
        bad = 0;
        foreach (obs_lba[i])
            if (obs_lba[i] !== ((32'(s) << N) + 32'(i)) || obs_rd[i] !== ld) bad++;
        chk("xfer_count", obs_lba.size(), 16);
        chk("xfer_seq", bad, 0);
        chk("xfer_hold", hb, 0);
        chk("xfer_done", done_cnt - d0, 1);
        chk("xfer_err", err_cnt - e0, 0);
        chk("xfer_rd_wr_both", both_cnt - b0, 0);
        chk("xfer_final_lba", sd_lba, (32'(s) << N) + 32'd15);
    endtask

    initial begin
        int d0, e0, hb, n, ea, wcnt, bad;
        bit fin;
        vecs[0] = '{1, 1, 0, 0, 1, 0, 1, 1};
        vecs[1] = '{1, 0, 1, 0, 0, 1, 1, 1};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
        vecs[3] = '{0, 0, 1, 0, 0, 0, 1, 0};
        vecs[4] = '{1, 1, 1, 0, 1, 0, 1, 1};
        vecs[5] = '{1, 1, 0, 1, 0, 0, 0, 1};
        vecs[6] = '{0, 1, 0, 1, 0, 0, 0, 1};
        vecs[7] = '{1, 1, 1, 1, 0, 0, 0, 1};

        #2 reset_n = 0;
        repeat (3) @(negedge clk_sys);
        chk("rst_lba", sd_lba, 0);
        chk("rst_rd_wr", {sd_rd, sd_wr}, 0);
        chk("rst_port_sel", port_sel, 1);
        chk("rst_fmt", {fmt_addr, fmt_data, fmt_we}, 0);
        chk("rst_hold_busy", {core_hold, busy, done, err}, 0);
        reset_n = 1;
        @(negedge clk_sys);

        foreach (vecs[k]) begin
            d0 = done_cnt;
            @(negedge clk_sys);
            bk_ena = vecs[k].bk;
            load_req = vecs[k].ld;
            save_req = vecs[k].sv;
            format_req = vecs[k].fm;
            @(negedge clk_sys);
            chk($sformatf("vec%0d_rd", k), sd_rd, vecs[k].rd);
            chk($sformatf("vec%0d_wr", k), sd_wr, vecs[k].wr);
            chk($sformatf("vec%0d_port_sel", k), port_sel, vecs[k].ps);
            chk($sformatf("vec%0d_busy", k), busy, vecs[k].bsy);
            load_req = 0;
            save_req = 0;
            format_req = 0;
            wait_idle(vecs[k].rd, 0, hb);
            chk($sformatf("vec%0d_hold", k), hb, 0);
            chk($sformatf("vec%0d_done", k), done_cnt - d0, 32'(vecs[k].bsy));
            bk_ena = 1;
        end

        do_xfer(2'd2, 1, 0);
        do_xfer(2'd0, 0, 0);

        hps_rand = 1;
        for (int r = 0; r < 8; r++) do_xfer(2'($urandom), 1'($urandom), 1);
        hps_rand = 0;
        bk_ena = 1;

        d0 = done_cnt;
        @(negedge clk_sys);
        format_req = 1;
        fin = 0;
        n = 0;
        ea = 0;
        wcnt = 0;
        bad = 0;
        while (!fin && n < 6000) begin
            @(negedge clk_sys);
            n++;
            if (!busy) fin = 1;
            else if (!fmt_we) bad++;
            else begin
                if (fmt_addr !== AW'(ea) || fmt_data !== fmt_model(ea) || port_sel !== 1'b0) bad++;
                ea++;
                wcnt++;
            end
        end
        @(negedge clk_sys);
        format_req = 0;
        chk("fmt_finished", 32'(fin), 1);
        chk("fmt_we_cycles", wcnt, 1 << AW);
        chk("fmt_words", bad, 0);
        chk("fmt_done", done_cnt - d0, 1);
        chk("fmt_end_port_sel", port_sel, 1);
        chk("fmt_end_we", fmt_we, 0);

        hps_en = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk_sys);
        load_req = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            if (sd_rd) n++;
        end
        chk("to_rd_cycles", n, (1 << TOB) - 1);
        chk("to_err", err_cnt - e0, 1);
        chk("to_done", done_cnt - d0, 0);
        chk("to_idle", {sd_rd, core_hold, busy}, 0);
        load_req = 0;
        hps_en = 1;

        bk_ena = 1;
        slot = 2;
        @(negedge clk_sys);
        load_req = 1;
        fin = 0;
        n = 0;
        while (!fin && n < 2000) begin
            @(negedge clk_sys);
            n++;
            if (sd_lba == 32'h23) fin = 1;
        end
        chk("reach_lba23", 32'(fin), 1);
        reset_n = 0;
        #1;
        chk("mid_rst_lba", sd_lba, 0);
        chk("mid_rst_rd_wr", {sd_rd, sd_wr}, 0);
        chk("mid_rst_hold_busy", {core_hold, busy, done, err}, 0);
        chk("mid_rst_port_sel", port_sel, 1);
        repeat (2) @(negedge clk_sys);
        reset_n = 1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr || busy) n++;
        end
        chk("no_restart_after_rst", n, 0);
        load_req = 0;
        @(negedge clk_sys);
        do_xfer(2'd2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
